halfword_store_packer: RTL

- Store-side counterpart to the datapath's 16-to-32 sign extension: narrows 32-bit signed words back to 16-bit halfwords.
- Detects values that do not fit in 16 bits and packs pairs of halfwords into 32-bit memory write words with per-halfword enables.
- Sits between the register-file/ALU result stream and the data-memory write port.
- Uses valid/ready handshakes on both sides, with a one-halfword holding register and a one-word output register.

---
 rtl/halfword_store_packer.sv | 99 +++++++++
 1 files changed

// File: rtl/halfword_store_packer.sv
// Narrows signed 32-bit words to halfwords and packs pairs into masked 32-bit writes; define HALFWORD_STORE_PACKER_SAT_EN to saturate out-of-range values.
// Latency: word registered on the edge that accepts its second halfword (or flush); InReady drops only while an output word is stalled.
module halfword_store_packer #(
    parameter int COUNT_W = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               InValid,
    output logic               InReady,
    input  logic [31:0]        InData,
    input  logic               Flush,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [31:0]        OutData,
    output logic [1:0]         OutMask,
    output logic               OvfFlag,
    output logic [COUNT_W-1:0] OvfCount
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] hold;

    logic        in_fire;
    logic        out_fire;
    logic        flush_take;
    logic        fits;
    logic [15:0] narrowed;

    // A new word can be loaded whenever the output slot is empty or draining this cycle.
    assign InReady    = ~OutValid | OutReady;
    assign in_fire    = InValid & InReady;
    assign out_fire   = OutValid & OutReady;
    assign flush_take = Flush & InReady;

    assign fits = (&InData[31:15]) | ~(|InData[31:15]);

`ifdef HALFWORD_STORE_PACKER_SAT_EN
    assign narrowed = fits ? InData[15:0] : (InData[31] ? 16'h8000 : 16'h7FFF);
`else
    assign narrowed = InData[15:0];
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= EMPTY;
            hold     <= 16'h0;
            OutValid <= 1'b0;
            OutData  <= 32'h0;
            OutMask  <= 2'b00;
            OvfFlag  <= 1'b0;
            OvfCount <= '0;
        end else begin
            OvfFlag <= in_fire & ~fits;
            if (in_fire && !fits && (OvfCount != '1)) begin
                OvfCount <= OvfCount + 1'b1;
            end

            // A load below overrides this clear, giving back-to-back output words.
            if (out_fire) begin
                OutValid <= 1'b0;
            end

            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        hold <= narrowed;
                        if (flush_take) begin
                            OutValid <= 1'b1;
                            OutData  <= {16'h0, narrowed};
                            OutMask  <= 2'b01;
                        end else begin
                            state <= HALF;
                        end
                    end
                end
                HALF: begin
                    if (in_fire) begin
                        OutValid <= 1'b1;
                        OutData  <= {narrowed, hold};
                        OutMask  <= 2'b11;
                        state    <= EMPTY;
                    end else if (flush_take) begin
                        OutValid <= 1'b1;
                        OutData  <= {16'h0, hold};
                        OutMask  <= 2'b01;
                        state    <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
